pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for a 5-stage in-order pipeline: per-stage enables,
// IF/ID flush, ID/EX bubble, stage valid tracking and stall/flush counters.
module pipe_stall_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_use_stall,
   input  logic        dmem_busy,
   input  logic        branch_taken,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_en,
   output logic        id_ex_bubble,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        v_id,
   output logic        v_ex,
   output logic        v_mem,
   output logic        v_wb,
   output logic        retire,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [1:0] {
      MODE_NORMAL,
      MODE_FREEZE,
      MODE_FLUSH,
      MODE_LOAD_USE
   } mode_t;

   mode_t       mode;
   logic        v_id_next, v_ex_next, v_mem_next, v_wb_next;
   logic        stall_inc, flush_inc;
   logic [15:0] stall_cnt_next, flush_cnt_next;

   // A load-use request only matters when ID actually holds an instruction.
   always_comb begin
      mode = MODE_NORMAL;
      if (dmem_busy)
         mode = MODE_FREEZE;
      else if (branch_taken)
         mode = MODE_FLUSH;
      else if (load_use_stall && v_id)
         mode = MODE_LOAD_USE;
   end

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      v_id_next    = 1'b1;
      v_ex_next    = v_id;
      v_mem_next   = v_ex;
      v_wb_next    = v_mem;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      case (mode)
         MODE_FREEZE: begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
            v_id_next  = v_id;
            v_ex_next  = v_ex;
            v_mem_next = v_mem;
            v_wb_next  = v_wb;
            stall_inc  = 1'b1;
         end
         MODE_FLUSH: begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            v_id_next    = 1'b0;
            v_ex_next    = 1'b0;
            flush_inc    = 1'b1;
         end
         MODE_LOAD_USE: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            v_id_next    = v_id;
            v_ex_next    = 1'b0;
            stall_inc    = 1'b1;
         end
         default: ;
      endcase

      // Hold the pipeline quiet with a bubble in ID/EX while reset is applied.
      if (!rst_n) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_en     = 1'b0;
         id_ex_bubble = 1'b1;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
      end
   end

   assign retire = rst_n && v_wb && !dmem_busy;

   assign stall_cnt_next = (stall_inc && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
   assign flush_cnt_next = (flush_inc && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_id      <= 1'b0;
         v_ex      <= 1'b0;
         v_mem     <= 1'b0;
         v_wb      <= 1'b0;
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         v_id      <= v_id_next;
         v_ex      <= v_ex_next;
         v_mem     <= v_mem_next;
         v_wb      <= v_wb_next;
         stall_cnt <= stall_cnt_next;
         flush_cnt <= flush_cnt_next;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; expected values are hand-derived and
// checked with immediate assertions.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_use_stall, dmem_busy, branch_taken;
   logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en;
   logic        v_id, v_ex, v_mem, v_wb, retire;
   logic [15:0] stall_cnt, flush_cnt;

   int tests  = 0;
   int failed = 0;

   // Enable vector order: pc, if_id, if_id_flush, id_ex, id_ex_bubble, ex_mem, mem_wb
   localparam logic [6:0] EN_NORMAL = 7'b1101011;
   localparam logic [6:0] EN_FREEZE = 7'b0000000;
   localparam logic [6:0] EN_FLUSH  = 7'b1111111;
   localparam logic [6:0] EN_LOAD   = 7'b0001111;
   localparam logic [6:0] EN_RESET  = 7'b0000100;

   always #5 clk = ~clk;

   pipe_stall_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_use_stall (load_use_stall),
      .dmem_busy      (dmem_busy),
      .branch_taken   (branch_taken),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .if_id_flush    (if_id_flush),
      .id_ex_en       (id_ex_en),
      .id_ex_bubble   (id_ex_bubble),
      .ex_mem_en      (ex_mem_en),
      .mem_wb_en      (mem_wb_en),
      .v_id           (v_id),
      .v_ex           (v_ex),
      .v_mem          (v_mem),
      .v_wb           (v_wb),
      .retire         (retire),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   wire [6:0] en_vec = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en};
   wire [3:0] v_vec  = {v_id, v_ex, v_mem, v_wb};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; sample/drive 1 time unit afterwards.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic lu, input logic busy, input logic br);
      load_use_stall = lu;
      dmem_busy      = busy;
      branch_taken   = br;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0);
      tick();
      tick();
      check("rst_valid", v_vec, 4'b0000);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      check("rst_enables", en_vec, EN_RESET);
      check("rst_retire", retire, 0);

      // Reset release: valid bits fill one stage per edge
      rst_n = 1'b1;
      tick(); check("fill_e1", v_vec, 4'b1000);
      check("fill_e1_en", en_vec, EN_NORMAL);
      tick(); check("fill_e2", v_vec, 4'b1100);
      tick(); check("fill_e3", v_vec, 4'b1110);
      check("fill_e3_retire", retire, 0);
      tick(); check("fill_e4", v_vec, 4'b1111);
      check("fill_e4_retire", retire, 1);
      check("fill_counters", {stall_cnt, flush_cnt}, 0);

      // Single load-use stall
      drive(1, 0, 0);
      check("lu_enables", en_vec, EN_LOAD);
      tick(); drive(0, 0, 0);
      check("lu_next_valid", v_vec, 4'b1011);
      check("lu_stall_cnt", stall_cnt, 1);
      check("lu_retire_t1", retire, 1);
      tick(); check("lu_valid_t2", v_vec, 4'b1101);
      check("lu_retire_t2", retire, 1);
      tick(); check("lu_valid_t3", v_vec, 4'b1110);
      check("lu_retire_t3", retire, 0);
      tick(); check("lu_retire_t4", retire, 1);

      // Branch and load-use together: flush wins, load-use discarded
      drive(1, 0, 1);
      check("br_lu_enables", en_vec, EN_FLUSH);
      tick();
      check("br_valid", v_vec, 4'b0011);
      check("br_flush_cnt", flush_cnt, 1);
      check("br_stall_cnt", stall_cnt, 1);
      // Load-use with empty ID is ignored
      drive(1, 0, 0);
      check("lu_noid_enables", en_vec, EN_NORMAL);
      tick(); drive(0, 0, 0);
      check("lu_noid_valid", v_vec, 4'b1001);
      check("lu_noid_stall_cnt", stall_cnt, 1);
      tick(); tick(); tick();
      check("refill_valid", v_vec, 4'b1111);

      // dmem_busy with branch held for 3 cycles, then flush
      drive(0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         check("busy_br_enables", en_vec, EN_FREEZE);
         check("busy_retire", retire, 0);
         tick();
         check("busy_valid_hold", v_vec, 4'b1111);
      end
      check("busy_stall_cnt", stall_cnt, 4);
      check("busy_flush_cnt", flush_cnt, 1);
      drive(0, 0, 1);
      check("post_busy_flush_en", en_vec, EN_FLUSH);
      tick(); drive(0, 0, 0);
      check("post_busy_flush_cnt", flush_cnt, 2);
      check("post_busy_valid", v_vec, 4'b0011);
      tick(); tick(); tick(); tick();
      check("refill2_valid", v_vec, 4'b1111);

      // Load-use raised during busy takes effect when busy drops
      drive(1, 1, 0);
      check("lu_busy_enables", en_vec, EN_FREEZE);
      tick();
      check("lu_busy_stall_cnt", stall_cnt, 5);
      drive(1, 0, 0);
      check("lu_after_busy_en", en_vec, EN_LOAD);
      tick(); drive(0, 0, 0);
      check("lu_after_busy_valid", v_vec, 4'b1011);
      check("lu_after_busy_stall", stall_cnt, 6);

      // Saturation of stall_cnt
      drive(0, 1, 0);
      repeat (65540) tick();
      check("sat_stall_cnt", stall_cnt, 16'hFFFF);
      check("sat_valid_hold", v_vec, 4'b1011);
      tick();
      check("sat_no_wrap", stall_cnt, 16'hFFFF);

      // Mid-cycle asynchronous reset with a branch pending
      drive(0, 0, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_stall", stall_cnt, 0);
      check("async_rst_flush", flush_cnt, 0);
      check("async_rst_valid", v_vec, 4'b0000);
      check("async_rst_enables", en_vec, EN_RESET);
      tick();
      check("rst_discard_flush", flush_cnt, 0);
      drive(0, 0, 0);
      rst_n = 1'b1;
      tick();
      check("rerelease_valid", v_vec, 4'b1000);
      check("rerelease_counters", {stall_cnt, flush_cnt}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
